// File: rtl/chacha_stream.sv
// ChaCha keystream generator with byte-serial key/nonce/counter load and 64-byte block read.
// One quarter round per cycle on a shared datapath; round count and counter width are parameters.
module chacha_stream #(
  parameter int unsigned ROUNDS    = 20,
  parameter int unsigned CTR_BYTES = 8,
  parameter int unsigned AUTO_INC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_key,
  input  logic       wr_nnc,
  input  logic       wr_ctr,
  input  logic       hold,
  output logic       blk_ready,
  input  logic       rd_blk,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned NNC_BYTES = 16 - CTR_BYTES;
  localparam int unsigned NQR       = ROUNDS * 4;

  typedef logic [15:0][31:0]          words_t;
  typedef logic [8*CTR_BYTES-1:0]     ctr_t;
  typedef enum logic [2:0] {LOAD_KEY, LOAD_NNC, LOAD_CTR, CALC, READY, READ} fsm_t;

  function automatic words_t f_init(input logic [31:0][7:0] key, input logic [15:0][7:0] cn);
    words_t s;
    s[0] = 32'h61707865;
    s[1] = 32'h3320646e;
    s[2] = 32'h79622d32;
    s[3] = 32'h6b206574;
    for (int unsigned i = 0; i < 8; i++) s[4'(4 + i)] = key[5'(4 * i) +: 4];
    for (int unsigned i = 0; i < 4; i++) s[4'(12 + i)] = cn[4'(4 * i) +: 4];
    return s;
  endfunction

  function automatic logic [31:0] f_rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  fsm_t               r_state;
  logic [5:0]         r_idx;
  logic [6:0]         r_qr;
  logic [31:0][7:0]   r_key;
  logic [15:0][7:0]   r_cn;
  words_t             r_w;
  logic               r_ready;

  logic               w_open, w_acc_key, w_acc_nnc, w_acc_ctr, w_wr_acc, w_rd_acc;
  logic               w_rd_done, w_ld_done;
  logic [31:0][7:0]   w_key_nx;
  logic [15:0][7:0]   w_cn_nx;
  words_t             w_sin, w_sin_nx;
  logic [1:0]         w_lb, w_lc, w_ld;
  logic [3:0]         w_ia, w_ib, w_ic, w_id;
  logic [31:0]        w_a1, w_a2, w_b1, w_b2, w_c1, w_c2, w_d1, w_d2;
  logic [5:0]         w_rd_idx;
  logic [31:0]        w_sum;

  always_comb begin
    w_open    = r_state inside {CALC, READY, READ};
    w_acc_key = w_open && wr_key;
    w_acc_nnc = w_open && !wr_key && wr_nnc;
    w_acc_ctr = w_open && !wr_key && !wr_nnc && wr_ctr;
    w_wr_acc  = w_acc_key || w_acc_nnc || w_acc_ctr;
    w_rd_acc  = (r_state == READY) && rd_blk && !w_wr_acc;
    w_rd_done = (r_state == READ) && (r_idx == 6'd63) && !w_wr_acc;
    w_ld_done = ((r_state == LOAD_KEY) && (r_idx == 6'd31)) ||
                ((r_state == LOAD_NNC) && (r_idx == 6'(NNC_BYTES - 1))) ||
                ((r_state == LOAD_CTR) && (r_idx == 6'(CTR_BYTES - 1)));

    // Byte 0 is captured in the strobe cycle, later bytes from the LOAD_* states.
    w_key_nx = r_key;
    w_cn_nx  = r_cn;
    if (w_acc_key)      w_key_nx[0] = data_in;
    else if (w_acc_nnc) w_cn_nx[4'(CTR_BYTES)] = data_in;
    else if (w_acc_ctr) w_cn_nx[0] = data_in;
    case (r_state)
      LOAD_KEY: w_key_nx[r_idx[4:0]] = data_in;
      LOAD_NNC: w_cn_nx[4'(CTR_BYTES) + r_idx[3:0]] = data_in;
      LOAD_CTR: w_cn_nx[r_idx[3:0]] = data_in;
      default: ;
    endcase
    if (AUTO_INC != 0 && w_rd_done)
      w_cn_nx[CTR_BYTES-1:0] = r_cn[CTR_BYTES-1:0] + ctr_t'(1);

    w_sin    = f_init(r_key, r_cn);
    w_sin_nx = f_init(w_key_nx, w_cn_nx);

    // Columns for qr 0-3, diagonals for qr 4-7 within each double round.
    if (r_qr[2]) begin
      w_lb = r_qr[1:0] + 2'd1;
      w_lc = r_qr[1:0] + 2'd2;
      w_ld = r_qr[1:0] + 2'd3;
    end else begin
      w_lb = r_qr[1:0];
      w_lc = r_qr[1:0];
      w_ld = r_qr[1:0];
    end
    w_ia = {2'b00, r_qr[1:0]};
    w_ib = {2'b01, w_lb};
    w_ic = {2'b10, w_lc};
    w_id = {2'b11, w_ld};

    w_a1 = r_w[w_ia] + r_w[w_ib];
    w_d1 = f_rotl(r_w[w_id] ^ w_a1, 16);
    w_c1 = r_w[w_ic] + w_d1;
    w_b1 = f_rotl(r_w[w_ib] ^ w_c1, 12);
    w_a2 = w_a1 + w_b1;
    w_d2 = f_rotl(w_d1 ^ w_a2, 8);
    w_c2 = w_c1 + w_d2;
    w_b2 = f_rotl(w_b1 ^ w_c2, 7);

    w_rd_idx  = (r_state == READ) ? r_idx : '0;
    w_sum     = r_w[w_rd_idx[5:2]] + w_sin[w_rd_idx[5:2]];
    data_out  = (w_rd_acc || ((r_state == READ) && !w_wr_acc)) ?
                8'(w_sum >> {w_rd_idx[1:0], 3'b000}) : '0;
    blk_ready = r_ready && !w_rd_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CALC;
      r_idx   <= '0;
      r_qr    <= '0;
      r_key   <= '0;
      r_cn    <= '0;
      r_w     <= f_init('0, '0);
      r_ready <= 1'b0;
    end else begin
      r_key <= w_key_nx;
      r_cn  <= w_cn_nx;
      if (w_wr_acc) begin
        r_ready <= 1'b0;
        r_idx   <= 6'd1;
        r_state <= w_acc_key ? LOAD_KEY : (w_acc_nnc ? LOAD_NNC : LOAD_CTR);
      end else begin
        case (r_state)
          LOAD_KEY, LOAD_NNC, LOAD_CTR: begin
            if (w_ld_done) begin
              r_w     <= w_sin_nx;
              r_qr    <= '0;
              r_state <= CALC;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
          CALC: begin
            if (!hold) begin
              r_w[w_ia] <= w_a2;
              r_w[w_ib] <= w_b2;
              r_w[w_ic] <= w_c2;
              r_w[w_id] <= w_d2;
              if (r_qr == 7'(NQR - 1)) begin
                r_qr    <= '0;
                r_ready <= 1'b1;
                r_state <= READY;
              end else begin
                r_qr <= r_qr + 7'd1;
              end
            end
          end
          READY: begin
            if (w_rd_acc) begin
              r_idx   <= 6'd1;
              r_ready <= 1'b0;
              r_state <= READ;
            end
          end
          READ: begin
            if (r_idx == 6'd63) begin
              if (AUTO_INC != 0) begin
                r_w     <= w_sin_nx;
                r_qr    <= '0;
                r_state <= CALC;
              end else begin
                r_ready <= 1'b1;
                r_state <= READY;
              end
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
          default: r_state <= CALC;
        endcase
      end
    end
  end

endmodule
